// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: MUL_STAGES-deep multiplier pipeline plus an iterative radix-2 divider.
// Optional build macro MULDIV_DIV_FAST_PATH_EN retires divide-by-zero and signed overflow without iterating.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 4,
  parameter int TAG_W      = 5
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       in_op_i,
  input  logic [XLEN-1:0]  in_op1_i,
  input  logic [XLEN-1:0]  in_op2_i,
  input  logic [TAG_W-1:0] in_tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_data_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             busy_o
);

  // Handshake: a transfer happens at a rising edge where valid && ready are both high;
  // once out_valid_o is raised, data and tag hold until out_ready_i takes them (or a flush/reset).
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;
  localparam int         CNT_W    = $clog2(XLEN + 1);

  logic [1:0]            div_state;
  logic [CNT_W-1:0]      div_cnt;
  logic [XLEN-1:0]       div_r, div_q, div_d;
  logic                  div_neg_q, div_neg_r, div_rem;
  logic [TAG_W-1:0]      div_tag;

  logic [MUL_STAGES-1:0] mul_v;
  logic [TAG_W-1:0]      mul_tag [MUL_STAGES];
  logic [XLEN:0]         m0_a, m0_b;
  logic                  m0_hi;
  logic [2*XLEN-1:0]     prod;
  logic [XLEN-1:0]       prod_sel, mul_out;

  logic out_valid_int, stall, mul_any, mul_last, div_done;
  logic is_div_op, in_ready_int, acc_mul, acc_div;
  logic mul_s1, mul_s2;
  logic div_sgn, s1, s2, div_zero;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   r_sh;
  logic            ge;
  logic [XLEN-1:0] diff_lo, r_next, q_fix, r_fix, div_res;

  assign mul_any       = |mul_v;
  assign mul_last      = mul_v[MUL_STAGES-1];
  assign div_done      = (div_state == DIV_DONE);
  assign out_valid_int = div_done || mul_last;
  assign stall         = out_valid_int && !out_ready_i;

  // Divides wait for an empty multiplier so results retire in issue order.
  assign is_div_op    = in_op_i[2];
  assign in_ready_int = reset_ni && !flush_i && (div_state == DIV_IDLE) && !stall
                        && (!is_div_op || !mul_any);
  assign in_ready_o   = in_ready_int;
  assign acc_mul      = in_valid_i && in_ready_int && !is_div_op;
  assign acc_div      = in_valid_i && in_ready_int && is_div_op;

  // ---------------- multiplier ----------------
  assign mul_s1   = (in_op_i[1:0] == 2'b01) || (in_op_i[1:0] == 2'b10);
  assign mul_s2   = (in_op_i[1:0] == 2'b01);
  assign prod     = {{(XLEN-1){m0_a[XLEN]}}, m0_a} * {{(XLEN-1){m0_b[XLEN]}}, m0_b};
  assign prod_sel = m0_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      mul_v <= '0;
    end else if (flush_i) begin
      mul_v <= '0;
    end else if (!stall) begin
      mul_v[0] <= acc_mul;
      for (int k = 1; k < MUL_STAGES; k++) mul_v[k] <= mul_v[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!stall) begin
      if (acc_mul) begin
        m0_a       <= {mul_s1 & in_op1_i[XLEN-1], in_op1_i};
        m0_b       <= {mul_s2 & in_op2_i[XLEN-1], in_op2_i};
        m0_hi      <= |in_op_i[1:0];
        mul_tag[0] <= in_tag_i;
      end
      for (int k = 1; k < MUL_STAGES; k++) mul_tag[k] <= mul_tag[k-1];
    end
  end

  generate
    if (MUL_STAGES == 1) begin : g_res_comb
      assign mul_out = prod_sel;
    end else begin : g_res_pipe
      logic [XLEN-1:0] res [1:MUL_STAGES-1];
      always_ff @(posedge clk_i) begin
        if (!stall) begin
          res[1] <= prod_sel;
          for (int k = 2; k < MUL_STAGES; k++) res[k] <= res[k-1];
        end
      end
      assign mul_out = res[MUL_STAGES-1];
    end
  endgenerate

  // ---------------- divider ----------------
  assign div_sgn  = !in_op_i[0];
  assign s1       = div_sgn && in_op1_i[XLEN-1];
  assign s2       = div_sgn && in_op2_i[XLEN-1];
  assign abs1     = s1 ? -in_op1_i : in_op1_i;
  assign abs2     = s2 ? -in_op2_i : in_op2_i;
  assign div_zero = (in_op2_i == '0);

`ifdef MULDIV_DIV_FAST_PATH_EN
  logic div_ovf;
  assign div_ovf = div_sgn && (in_op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (in_op2_i == '1);
`endif

  // Restoring step: the dividend shifts out of div_q while quotient bits shift in.
  assign r_sh    = {div_r, div_q[XLEN-1]};
  assign ge      = (r_sh >= {1'b0, div_d});
  assign diff_lo = r_sh[XLEN-1:0] - div_d;
  assign r_next  = ge ? diff_lo : r_sh[XLEN-1:0];

  assign q_fix   = div_neg_q ? -div_q : div_q;
  assign r_fix   = div_neg_r ? -div_r : div_r;
  assign div_res = div_rem ? r_fix : q_fix;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      div_state <= DIV_IDLE;
      div_cnt   <= '0;
    end else if (flush_i) begin
      div_state <= DIV_IDLE;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (acc_div) begin
`ifdef MULDIV_DIV_FAST_PATH_EN
            div_state <= (div_zero || div_ovf) ? DIV_DONE : DIV_BUSY;
`else
            div_state <= DIV_BUSY;
`endif
            div_cnt <= CNT_W'(XLEN);
          end
        end
        DIV_BUSY: begin
          div_cnt <= div_cnt - CNT_W'(1);
          if (div_cnt == CNT_W'(1)) div_state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (out_ready_i) div_state <= DIV_IDLE;
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  // Divide by zero keeps the all-ones quotient unsigned regardless of dividend sign.
  always_ff @(posedge clk_i) begin
    if (acc_div) begin
      div_tag   <= in_tag_i;
      div_rem   <= in_op_i[1];
      div_r     <= '0;
      div_q     <= abs1;
      div_d     <= abs2;
      div_neg_q <= (s1 ^ s2) && !div_zero;
      div_neg_r <= s1;
`ifdef MULDIV_DIV_FAST_PATH_EN
      if (div_zero) begin
        div_q <= '1;
        div_r <= abs1;
      end else if (div_ovf) begin
        div_q     <= in_op1_i;
        div_neg_q <= 1'b0;
      end
`endif
    end else if (div_state == DIV_BUSY) begin
      div_r <= r_next;
      div_q <= {div_q[XLEN-2:0], ge};
    end
  end

  // ---------------- outputs ----------------
  assign out_valid_o = reset_ni && out_valid_int;
  assign busy_o      = reset_ni && (mul_any || (div_state != DIV_IDLE));
  assign out_data_o  = !reset_ni ? '0 : div_done ? div_res : mul_last ? mul_out : '0;
  assign out_tag_o   = !reset_ni ? '0 : div_done ? div_tag : mul_last ? mul_tag[MUL_STAGES-1] : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32, MUL_STAGES=4): vector table, scoreboard and
// hand-written latency, stall, ordering, flush and reset sequences.
module tb_muldiv_unit;
  localparam int XLEN       = 32;
  localparam int MUL_STAGES = 4;
  localparam int TAG_W      = 5;
  localparam int W          = XLEN + TAG_W;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

`ifdef MULDIV_DIV_FAST_PATH_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = XLEN + 1;
`endif

  typedef struct {
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } vec_t;

  logic             clk;
  logic             reset_n;
  logic             in_valid, in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_op1, in_op2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid, out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op),
    .in_op1_i(in_op1), .in_op2_i(in_op2), .in_tag_i(in_tag),
    .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_tag_o(out_tag), .busy_o(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic             prev_stall = 1'b0;
  logic [XLEN-1:0]  prev_data;
  logic [TAG_W-1:0] prev_tag;
  logic [W-1:0]     e;

  always @(negedge clk) begin
    if (reset_n && !flush) begin
      if (prev_stall) begin
        check("stall_hold_valid", 64'(out_valid), 64'd1);
        check("stall_hold_result", 64'({out_tag, out_data}), 64'({prev_tag, prev_data}));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: tag %0d data 0x%0h, expected no output", out_tag, out_data);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("result_tag%0d", e[W-1:XLEN]), 64'({out_tag, out_data}), 64'(e));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_model(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    longint      sa, sb, ub, ps;
    logic [63:0] pu;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    ref_model = '0;
    case (op)
      OP_MUL:    begin pu = {32'h0, a} * {32'h0, b}; ref_model = pu[31:0]; end
      OP_MULH:   begin ps = sa * sb; ref_model = ps[63:32]; end
      OP_MULHSU: begin ps = sa * ub; ref_model = ps[63:32]; end
      OP_MULHU:  begin pu = {32'h0, a} * {32'h0, b}; ref_model = pu[63:32]; end
      OP_DIV:
        if (b == 0) ref_model = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_model = a;
        else ref_model = 32'(ia / ib);
      OP_DIVU:   ref_model = (b == 0) ? '1 : a / b;
      OP_REM:
        if (b == 0) ref_model = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_model = '0;
        else ref_model = 32'(ia % ib);
      default:   ref_model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp, output int acc);
    int n;
    n   = 0;
    acc = -1;
    in_valid = 1'b1; in_op = op; in_op1 = a; in_op2 = b; in_tag = tag;
    while (acc < 0 && n <= 200) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        exp_q.push_back({tag, exp});
      end
      n++;
    end
    if (acc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: op %0d tag %0d not accepted within 200 cycles", op, tag);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int oc);
    int n;
    n  = 0;
    oc = -1;
    while (oc < 0 && n <= 200) begin
      @(negedge clk);
      if (out_valid) oc = cyc;
      n++;
    end
    if (oc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL output_timeout: no out_valid within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[$];
  int   acc, acc2, oc, cnt, base;

  task automatic add(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [XLEN-1:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_op = OP_MUL; in_op1 = '0; in_op2 = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // MUL latency and value
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, acc);
    wait_out(oc);
    check("mul_latency", 64'(oc - acc), 64'(MUL_STAGES));

    // Vector table: hand-computed corner cases then random ones checked against the model
    add(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    add(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    add(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    add(OP_MUL,    32'h1234_5678,  32'h10,        32'h2345_6780);
    add(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    add(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    add(OP_DIVU,   32'd100,        32'd7,         32'd14);
    add(OP_REMU,   32'd100,        32'd7,         32'd2);
    add(OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF);
    add(OP_REM,    32'd5,          32'd0,         32'd5);
    add(OP_DIVU,   32'd0,          32'd0,         32'hFFFF_FFFF);
    add(OP_REMU,   32'd9,          32'd0,         32'd9);
    add(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    add(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
    add(OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD);
    add(OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1);
    add(OP_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF);
    add(OP_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9);
    for (int i = 0; i < 12; i++) begin
      logic [2:0]      op;
      logic [XLEN-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      add(op, a, b, ref_model(op, a, b));
    end
    for (int i = 0; i < vecs.size(); i++)
      issue(vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i), vecs[i].exp, acc);
    drain();

    // Back-to-back multiplies with a 3-cycle output stall
    base = n_out;
    fork
      begin
        for (int t = 1; t <= 6; t++)
          issue(OP_MUL, 32'(t * 3 + 1), -32'(t), TAG_W'(t),
                ref_model(OP_MUL, 32'(t * 3 + 1), -32'(t)), acc2);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_result_count", 64'(n_out - base), 64'd6);

    // DIVU latency and in_ready held low while dividing
    issue(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, acc);
    cnt = 0;
    oc  = -1;
    for (int k = 1; k <= XLEN + 1; k++) begin
      @(negedge clk);
      if (in_ready) cnt++;
      if (out_valid && oc < 0) oc = cyc;
    end
    check("divu_in_ready_low_cycles", 64'(cnt), 64'd0);
    check("divu_latency", 64'(oc - acc), 64'(XLEN + 1));
    @(posedge clk);
    #1;

    // Special-case latency
    issue(OP_DIV, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF, acc);
    wait_out(oc);
    check("div_by_zero_latency", 64'(oc - acc), 64'(SPECIAL_LAT));
    issue(OP_REM, 32'd5, 32'd0, 5'd5, 32'd5, acc);
    wait_out(oc);
    check("rem_by_zero_latency", 64'(oc - acc), 64'(SPECIAL_LAT));
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, acc);
    wait_out(oc);
    check("div_overflow_latency", 64'(oc - acc), 64'(SPECIAL_LAT));
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0, acc);
    wait_out(oc);
    check("rem_overflow_latency", 64'(oc - acc), 64'(SPECIAL_LAT));
    drain();

    // DIV offered right behind a MUL waits until the pipeline has emptied
    issue(OP_MUL, 32'd6, 32'd7, 5'd10, 32'd42, acc);
    issue(OP_DIV, 32'd42, 32'd6, 5'd11, 32'd7, acc2);
    check("div_after_mul_accept_cycle", 64'(acc2 - acc), 64'(MUL_STAGES + 1));
    drain();

    // Flush in the middle of a division, with a concurrent offer
    issue(OP_DIV, 32'd1000, 32'd3, 5'd12, 32'd333, acc);
    repeat (14) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1; in_op = OP_MUL; in_op1 = 32'd2; in_op2 = 32'd3; in_tag = 5'd13;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid_after", 64'(out_valid), 64'd0);
    check("flush_busy_after", 64'(busy), 64'd0);
    cnt = 0;
    for (int k = 0; k < XLEN + 4; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("flush_no_late_output", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'h2, 5'd14, 32'd1, acc);
    wait_out(oc);
    check("post_flush_mul_latency", 64'(oc - acc), 64'(MUL_STAGES));

    // Reset with three multiplies in flight
    issue(OP_MUL, 32'd2, 32'd2, 5'd20, 32'd4, acc);
    issue(OP_MUL, 32'd3, 32'd3, 5'd21, 32'd9, acc);
    issue(OP_MUL, 32'd4, 32'd4, 5'd22, 32'd16, acc);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd0);
    check("midreset_out_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("postreset_busy", 64'(busy), 64'd0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("postreset_no_output", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;
    issue(OP_DIVU, 32'd81, 32'd9, 5'd23, 32'd9, acc);
    wait_out(oc);
    check("post_reset_div_latency", 64'(oc - acc), 64'(XLEN + 1));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
